// File: rtl/llm_params.sv
// rtl/llm_params.sv - shared widths, policy encoding and record types for the prefetch engine
package llm_params;

    localparam int CHI_ADDR_WIDTH  = 32;
    localparam int OFFSET_WIDTH    = 6;
    localparam int CACHELINE_SIZE  = 1 << OFFSET_WIDTH;
    localparam int PF_REGION_WIDTH = 12;
    localparam int PF_STRIDE_WIDTH = 8;
    localparam int PF_CONF_WIDTH   = 2;
    localparam int PF_LINE_WIDTH   = CHI_ADDR_WIDTH - OFFSET_WIDTH;
    localparam int PF_TAG_WIDTH    = CHI_ADDR_WIDTH - PF_REGION_WIDTH;

    typedef enum logic [1:0] {
        PF_SEQ      = 2'b00,
        PF_STRIDE   = 2'b01,
        PF_ADAPTIVE = 2'b10,
        PF_RSVD     = 2'b11
    } pf_policy_e;

    typedef struct packed {
        logic                       valid;
        logic [PF_TAG_WIDTH-1:0]    tag;
        logic [PF_LINE_WIDTH-1:0]   last_line;
        logic [PF_STRIDE_WIDTH-1:0] stride;
        logic [PF_CONF_WIDTH-1:0]   conf;
    } pf_stream_t;

    typedef struct packed {
        logic [PF_LINE_WIDTH-1:0] line;
        logic [2:0]               pri;
    } pf_req_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/llm_prefetch_engine_if.sv
// rtl/llm_prefetch_engine_if.sv - prefetch issue channel; the engine is master, the cache side is slave
interface llm_prefetch_engine_if import llm_params::*; #(
    parameter int ADDR_W = CHI_ADDR_WIDTH
);
    logic              prefetch_valid;
    logic [ADDR_W-1:0] prefetch_addr;
    logic [2:0]        prefetch_priority;
    logic              prefetch_ready;

    modport master (output prefetch_valid, prefetch_addr, prefetch_priority, input prefetch_ready);
    modport slave  (input prefetch_valid, prefetch_addr, prefetch_priority, output prefetch_ready);
endinterface

// File: rtl/llm_pf_fifo.sv
// rtl/llm_pf_fifo.sv - synchronous FIFO with flush; push while full is accepted only alongside a pop
module llm_pf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/llm_prefetch_engine.sv
// rtl/llm_prefetch_engine.sv - multi-stream stride prefetcher: stream table, burst generator, issue FIFO
module llm_prefetch_engine import llm_params::*; #(
    parameter int ADDR_W      = CHI_ADDR_WIDTH,
    parameter int OFFSET_W    = OFFSET_WIDTH,
    parameter int REGION_W    = PF_REGION_WIDTH,
    parameter int NUM_STREAMS = 4,
    parameter int MAX_DEPTH   = 8,
    parameter int STRIDE_W    = PF_STRIDE_WIDTH,
    parameter int CONF_W      = PF_CONF_WIDTH,
    parameter int CONF_THRESH = 2,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         prefetch_en,
    input  logic [1:0]                   prefetch_policy,
    input  logic [$clog2(MAX_DEPTH)-1:0] prefetch_depth,
    input  logic                         train_writes,
    input  logic                         access_valid,
    input  logic [ADDR_W-1:0]            access_addr,
    input  logic                         access_is_write,
    llm_prefetch_engine_if.master        pf,
    input  logic                         fb_valid,
    input  logic                         fb_hit,
    output logic [31:0]                  prefetch_count,
    output logic [31:0]                  prefetch_hit_count,
    output logic [31:0]                  prefetch_miss_count,
    output logic [31:0]                  prefetch_drop_count,
    output logic [$clog2(MAX_DEPTH):0]   eff_depth
);
    localparam int LINE_W  = ADDR_W - OFFSET_W;
    localparam int TAG_W   = ADDR_W - REGION_W;
    localparam int PAGE_SH = REGION_W - OFFSET_W;
    localparam int DW      = $clog2(MAX_DEPTH) + 1;
    localparam int IW      = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int CW      = $clog2(QUEUE_DEPTH + 1);

    pf_policy_e        policy;
    pf_stream_t        tbl [NUM_STREAMS];
    pf_stream_t        cur, upd, fresh;
    logic [IW-1:0]     victim, hit_idx, free_idx;
    logic              train, hit, has_free, fits, in_range, confirm, trigger;
    logic [LINE_W-1:0] acc_line, delta, stride_ext;
    logic [TAG_W-1:0]  acc_tag;
    logic              unused_ok;

    assign policy    = pf_policy_e'(prefetch_policy);
    assign train     = access_valid && prefetch_en && (!access_is_write || train_writes);
    assign acc_line  = access_addr[ADDR_W-1:OFFSET_W];
    assign acc_tag   = access_addr[ADDR_W-1:REGION_W];
    assign unused_ok = ^access_addr[OFFSET_W-1:0];

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].tag == acc_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!tbl[i].valid) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
        cur        = tbl[hit_idx];
        delta      = acc_line - cur.last_line;
        stride_ext = {{(LINE_W - STRIDE_W){cur.stride[STRIDE_W-1]}}, cur.stride};
        fits       = (&delta[LINE_W-1:STRIDE_W-1]) || !(|delta[LINE_W-1:STRIDE_W-1]);
        in_range   = fits && (policy != PF_SEQ || delta == LINE_W'(1) || delta == '1);
        upd           = cur;
        upd.last_line = acc_line;
        confirm       = 1'b0;
        if (delta != '0) begin
            if (!in_range) begin
                upd.conf = '0;
            end else if (delta == stride_ext) begin
                confirm = 1'b1;
                if (cur.conf != '1) upd.conf = cur.conf + 1'b1;
            end else begin
                upd.stride = delta[STRIDE_W-1:0];
                upd.conf   = '0;
            end
        end
        fresh           = '0;
        fresh.valid     = 1'b1;
        fresh.tag       = acc_tag;
        fresh.last_line = acc_line;
    end

    // The delta that first sets a stride counts as one sighting, so conf+1 matching deltas are on record.
    assign trigger = train && hit && confirm && upd.stride != '0 && upd.conf >= CONF_W'(CONF_THRESH - 1);

    always_ff @(posedge clk) begin
        if (rst || !prefetch_en) begin
            for (int i = 0; i < NUM_STREAMS; i++) tbl[i] <= '0;
            if (rst) victim <= '0;
        end else if (train) begin
            if (hit) begin
                tbl[hit_idx] <= upd;
            end else if (has_free) begin
                tbl[free_idx] <= fresh;
            end else begin
                tbl[victim] <= fresh;
                victim      <= (victim == IW'(NUM_STREAMS - 1)) ? '0 : victim + 1'b1;
            end
        end
    end

    logic              gen_busy, page_end, push_ok, pop, full, empty;
    logic [LINE_W-1:0] gen_line, gen_stride;
    logic [TAG_W-1:0]  gen_tag;
    logic [DW-1:0]     gen_rem, rem_after;
    logic [2:0]        gen_pri;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       drop_add;
    pf_req_t           wr_req, head;

    assign page_end  = gen_busy && gen_line[LINE_W-1:PAGE_SH] != gen_tag;
    assign pop       = !empty && pf.prefetch_ready;
    assign push_ok   = gen_busy && prefetch_en && !page_end && (!full || pop);
    assign rem_after = gen_rem - DW'(push_ok);
    assign wr_req    = '{line: gen_line, pri: gen_pri};

    always_comb begin
        drop_add = '0;
        if (!prefetch_en) begin
            drop_add = 32'(fifo_count) - 32'(pop);
            if (gen_busy) drop_add = drop_add + 32'(gen_rem);
        end else if (page_end) begin
            drop_add = 32'(gen_rem);
        end else if (trigger && gen_busy) begin
            drop_add = 32'(rem_after);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !prefetch_en) begin
            gen_busy <= 1'b0;
        end else if (trigger) begin
            gen_busy   <= 1'b1;
            gen_line   <= acc_line + stride_ext;
            gen_stride <= stride_ext;
            gen_tag    <= acc_tag;
            gen_rem    <= eff_depth;
            gen_pri    <= 3'(upd.conf);
        end else if (page_end) begin
            gen_busy <= 1'b0;
        end else if (push_ok) begin
            gen_line <= gen_line + gen_stride;
            gen_rem  <= rem_after;
            gen_busy <= (rem_after != '0);
        end
    end

    llm_pf_fifo #(.WIDTH($bits(pf_req_t)), .DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!prefetch_en),
        .push  (push_ok),
        .wdata (wr_req),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign pf.prefetch_valid    = !empty;
    assign pf.prefetch_addr     = empty ? '0 : {head.line, {OFFSET_W{1'b0}}};
    assign pf.prefetch_priority = empty ? '0 : head.pri;

    logic [3:0] win_cnt;
    logic [4:0] win_hits, win_total;
    assign win_total = win_hits + 5'(fb_hit);

    always_ff @(posedge clk) begin
        if (rst || policy != PF_ADAPTIVE) begin
            eff_depth <= DW'(prefetch_depth) + 1'b1;
            win_cnt   <= '0;
            win_hits  <= '0;
        end else if (fb_valid) begin
            if (win_cnt == 4'd15) begin
                if (win_total >= 5'd12 && eff_depth != DW'(MAX_DEPTH)) eff_depth <= eff_depth + 1'b1;
                else if (win_total < 5'd8 && eff_depth != DW'(1))      eff_depth <= eff_depth - 1'b1;
                win_cnt  <= '0;
                win_hits <= '0;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                win_hits <= win_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefetch_count      <= '0;
            prefetch_hit_count  <= '0;
            prefetch_miss_count <= '0;
            prefetch_drop_count <= '0;
        end else begin
            if (pop)                 prefetch_count      <= sat_add(prefetch_count, 32'd1);
            if (fb_valid && fb_hit)  prefetch_hit_count  <= sat_add(prefetch_hit_count, 32'd1);
            if (fb_valid && !fb_hit) prefetch_miss_count <= sat_add(prefetch_miss_count, 32'd1);
            if (drop_add != '0)      prefetch_drop_count <= sat_add(prefetch_drop_count, drop_add);
        end
    end
endmodule
